// File: rtl/lfsr_search_scheduler.sv
// Round-robin scheduler that shares one external lfsr between several requesters.
// It walks the lfsr sequence to find each target word's iteration offset.
module lfsr_search_scheduler #(
  parameter int          NUM_REQ    = 4,
  parameter logic [16:0] POLY0      = 17'h1D258,
  parameter logic [16:0] POLY1      = 17'h17E04,
  parameter logic [16:0] START_SEED = 17'h00001,
  parameter logic [16:0] MAX_ITER   = 17'h1FFFF
) (
  input  logic                    clk_96MHz,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [17*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]      req_poly_sel,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    res_valid,
  output logic [2:0]              res_id,
  output logic                    res_found,
  output logic [16:0]             res_offset,
  output logic                    lfsr_enable,
  output logic [16:0]             lfsr_polynomial,
  output logic [16:0]             lfsr_start_data,
  input  logic [16:0]             lfsr_value,
  input  logic [16:0]             lfsr_iteration
);

  typedef enum logic [2:0] {
    S_GUARD,
    S_IDLE,
    S_ARM,
    S_SEARCH,
    S_REJECT,
    S_REPORT
  } state_t;

  state_t       r_state;
  logic         r_cnt;
  logic [2:0]   r_ptr;
  logic [2:0]   r_id;
  logic [16:0]  r_target;

  logic               w_grantAny;
  logic [2:0]         w_grantIdx;
  logic [2:0]         w_nextPtr;
  logic [NUM_REQ-1:0] w_grantOneHot;
  logic [16:0]        w_grantData;
  logic               w_grantSel;
  int                 w_bestDist;
  int                 w_dist;

  assign lfsr_start_data = START_SEED;

  // The winner is the valid requester with the smallest circular distance from the pointer.
  always_comb begin
    w_grantAny    = 1'b0;
    w_grantIdx    = '0;
    w_nextPtr     = '0;
    w_grantOneHot = '0;
    w_grantData   = '0;
    w_grantSel    = 1'b0;
    w_bestDist    = NUM_REQ;
    w_dist        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = i - int'(r_ptr);
      if (w_dist < 0) w_dist = w_dist + NUM_REQ;
      if (req_valid[i] && (w_dist < w_bestDist)) begin
        w_bestDist       = w_dist;
        w_grantAny       = 1'b1;
        w_grantIdx       = 3'(i);
        w_nextPtr        = 3'((i + 1) % NUM_REQ);
        w_grantOneHot    = '0;
        w_grantOneHot[i] = 1'b1;
        w_grantData      = req_data[17*i +: 17];
        w_grantSel       = req_poly_sel[i];
      end
    end
  end

  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      r_state         <= S_GUARD;
      r_cnt           <= 1'b0;
      r_ptr           <= '0;
      r_id            <= '0;
      r_target        <= '0;
      req_ready       <= '0;
      res_valid       <= 1'b0;
      res_id          <= '0;
      res_found       <= 1'b0;
      res_offset      <= '0;
      lfsr_enable     <= 1'b0;
      lfsr_polynomial <= POLY0;
    end else begin
      req_ready <= '0;
      res_valid <= 1'b0;
      case (r_state)
        // Two enable-low edges force the lfsr back to IDLE whatever it was doing.
        S_GUARD: begin
          lfsr_enable <= 1'b0;
          if (r_cnt) begin
            r_cnt   <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= 1'b1;
          end
        end
        S_IDLE: begin
          if (w_grantAny) begin
            req_ready <= w_grantOneHot;
            r_id      <= w_grantIdx;
            r_target  <= w_grantData;
            r_ptr     <= w_nextPtr;
            if (w_grantData == '0) begin
              r_state <= S_REJECT;
            end else begin
              lfsr_enable     <= 1'b1;
              lfsr_polynomial <= w_grantSel ? POLY1 : POLY0;
              r_cnt           <= 1'b0;
              r_state         <= S_ARM;
            end
          end
        end
        S_ARM: begin
          if (r_cnt) begin
            r_cnt   <= 1'b0;
            r_state <= S_SEARCH;
          end else begin
            r_cnt <= 1'b1;
          end
        end
        // A match at the final iteration still counts as found.
        S_SEARCH: begin
          if (lfsr_value == r_target) begin
            res_valid   <= 1'b1;
            res_id      <= r_id;
            res_found   <= 1'b1;
            res_offset  <= lfsr_iteration;
            lfsr_enable <= 1'b0;
            r_state     <= S_REPORT;
          end else if (lfsr_iteration == MAX_ITER) begin
            res_valid   <= 1'b1;
            res_id      <= r_id;
            res_found   <= 1'b0;
            res_offset  <= MAX_ITER;
            lfsr_enable <= 1'b0;
            r_state     <= S_REPORT;
          end
        end
        S_REJECT: begin
          res_valid  <= 1'b1;
          res_id     <= r_id;
          res_found  <= 1'b0;
          res_offset <= '0;
          r_state    <= S_REPORT;
        end
        S_REPORT: begin
          r_cnt   <= 1'b0;
          r_state <= S_GUARD;
        end
        default: r_state <= S_GUARD;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_search_scheduler.sv
// Bench for lfsr_search_scheduler: two instances (full and short MAX_ITER) driving a behavioural lfsr,
// with results compared against a plain sequence-search reference model.
module tb_lfsr_search_scheduler;

  localparam logic [16:0] POLY0      = 17'h1D258;
  localparam logic [16:0] POLY1      = 17'h17E04;
  localparam logic [16:0] START_SEED = 17'h00001;
  localparam int          MAX_A      = 17'h1FFFF;
  localparam int          MAX_B      = 50;

  typedef struct {
    logic [3:0]  grant;
    int          acceptCyc;
    int          resultCyc;
    logic [2:0]  id;
    logic        found;
    logic [16:0] offset;
    int          enHigh;
    int          polyBad;
    int          lowStreak;
    bit          timedOut;
    logic        validAfter;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  reqValid[2];
  logic [3:0]  reqPolySel[2];
  logic [3:0]  reqReady[2];
  logic [67:0] reqData[2];
  logic        resValid[2];
  logic        resFound[2];
  logic        lfsrEnable[2];
  logic [2:0]  resId[2];
  logic [16:0] resOffset[2];
  logic [16:0] lfsrPoly[2];
  logic [16:0] lfsrStart[2];
  logic [16:0] lfsrVal[2] = '{17'h0ABCD, 17'h1F00F};
  logic [16:0] lfsrIter[2] = '{17'h00123, 17'h00456};
  int          lfsrSt[2] = '{2, 2};
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lfsr_search_scheduler #(.NUM_REQ(4)) dutA (
    .clk_96MHz(clk), .reset(reset), .req_valid(reqValid[0]), .req_data(reqData[0]),
    .req_poly_sel(reqPolySel[0]), .req_ready(reqReady[0]), .res_valid(resValid[0]),
    .res_id(resId[0]), .res_found(resFound[0]), .res_offset(resOffset[0]),
    .lfsr_enable(lfsrEnable[0]), .lfsr_polynomial(lfsrPoly[0]), .lfsr_start_data(lfsrStart[0]),
    .lfsr_value(lfsrVal[0]), .lfsr_iteration(lfsrIter[0]));

  lfsr_search_scheduler #(.NUM_REQ(4), .MAX_ITER(17'd50)) dutB (
    .clk_96MHz(clk), .reset(reset), .req_valid(reqValid[1]), .req_data(reqData[1]),
    .req_poly_sel(reqPolySel[1]), .req_ready(reqReady[1]), .res_valid(resValid[1]),
    .res_id(resId[1]), .res_found(resFound[1]), .res_offset(resOffset[1]),
    .lfsr_enable(lfsrEnable[1]), .lfsr_polynomial(lfsrPoly[1]), .lfsr_start_data(lfsrStart[1]),
    .lfsr_value(lfsrVal[1]), .lfsr_iteration(lfsrIter[1]));

  function automatic logic [16:0] lfsrStep(input logic [16:0] v, input logic [16:0] poly);
    return (v >> 1) ^ (v[0] ? poly : 17'h0);
  endfunction

  function automatic logic [16:0] stateAt(input int n, input logic [16:0] poly);
    logic [16:0] v;
    v = START_SEED;
    for (int i = 0; i < n; i++) v = lfsrStep(v, poly);
    return v;
  endfunction

  // Reference: first iteration whose state equals the target, else timeout at maxIter.
  function automatic void refSearch(input logic [16:0] target, input logic [16:0] poly, input int maxIter,
                                    output logic found, output logic [16:0] off);
    logic [16:0] v;
    found = 1'b0;
    off   = 17'(maxIter);
    if (target == 17'h0) begin
      off = 17'h0;
      return;
    end
    v = START_SEED;
    for (int n = 0; n <= maxIter; n++) begin
      if (v == target) begin
        found = 1'b1;
        off   = 17'(n);
        return;
      end
      v = lfsrStep(v, poly);
    end
  endfunction

  // Behavioural lfsr: no reset, IDLE -> LOAD -> shifting, back to IDLE when enable drops.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!lfsrEnable[k]) lfsrSt[k] <= 0;
      else if (lfsrSt[k] == 0) lfsrSt[k] <= 1;
      else if (lfsrSt[k] == 1) begin
        lfsrVal[k]  <= lfsrStart[k];
        lfsrIter[k] <= 17'h0;
        lfsrSt[k]   <= 2;
      end else begin
        lfsrVal[k]  <= lfsrStep(lfsrVal[k], lfsrPoly[k]);
        lfsrIter[k] <= lfsrIter[k] + 17'd1;
      end
    end
  end

  task automatic pulseReset();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic runSearch(input int k, input int id, input logic [16:0] target, input logic sel, output obs_t o);
    int budget;
    logic [16:0] expPoly;
    expPoly = sel ? POLY1 : POLY0;
    o = '{default: 0};
    reqData[k][17*id +: 17] = target;
    reqPolySel[k][id] = sel;
    reqValid[k][id] = 1'b1;
    budget = 0;
    @(negedge clk);
    while (reqReady[k] == 4'h0 && budget < 100) begin
      if (lfsrEnable[k] == 1'b0) o.lowStreak++;
      else o.lowStreak = 0;
      budget++;
      @(negedge clk);
    end
    if (reqReady[k] == 4'h0) begin
      o.timedOut = 1'b1;
      reqValid[k][id] = 1'b0;
      return;
    end
    o.grant = reqReady[k];
    o.acceptCyc = cyc;
    reqValid[k][id] = 1'b0;
    budget = 0;
    while (resValid[k] == 1'b0 && budget < 5000) begin
      if (lfsrEnable[k]) begin
        o.enHigh++;
        if (lfsrPoly[k] !== expPoly) o.polyBad++;
      end
      budget++;
      @(negedge clk);
    end
    if (resValid[k] == 1'b0) begin
      o.timedOut = 1'b1;
      return;
    end
    o.resultCyc = cyc;
    o.id = resId[k];
    o.found = resFound[k];
    o.offset = resOffset[k];
    @(negedge clk);
    o.validAfter = resValid[k];
  endtask

  task automatic test_reset();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    checks += 9;
    if (reqReady[0] !== 4'h0) begin errors++; $display("[TB] FAIL reset_ready: got %h expected 0", reqReady[0]); end
    if (resValid[0] !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid: got %b expected 0", resValid[0]); end
    if (resId[0] !== 3'd0) begin errors++; $display("[TB] FAIL reset_res_id: got %0d expected 0", resId[0]); end
    if (resFound[0] !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_found: got %b expected 0", resFound[0]); end
    if (resOffset[0] !== 17'h0) begin errors++; $display("[TB] FAIL reset_res_offset: got %h expected 0", resOffset[0]); end
    if (lfsrEnable[0] !== 1'b0) begin errors++; $display("[TB] FAIL reset_enable: got %b expected 0", lfsrEnable[0]); end
    if (lfsrPoly[0] !== POLY0) begin errors++; $display("[TB] FAIL reset_poly: got %h expected %h", lfsrPoly[0], POLY0); end
    if (lfsrStart[0] !== START_SEED) begin errors++; $display("[TB] FAIL start_data: got %h expected %h", lfsrStart[0], START_SEED); end
    if (lfsrEnable[1] !== 1'b0) begin errors++; $display("[TB] FAIL reset_enable_b: got %b expected 0", lfsrEnable[1]); end
    reset = 1'b0;
  endtask

  task automatic test_seed_match();
    obs_t o;
    runSearch(0, 0, START_SEED, 1'b0, o);
    checks += 6;
    if (o.timedOut) begin errors++; $display("[TB] FAIL seed_timeout: got no response expected result"); end
    if (o.grant !== 4'b0001) begin errors++; $display("[TB] FAIL seed_grant: got %b expected 0001", o.grant); end
    if (o.resultCyc - o.acceptCyc != 3) begin errors++; $display("[TB] FAIL seed_latency: got %0d expected 3", o.resultCyc - o.acceptCyc); end
    if (o.found !== 1'b1 || o.offset !== 17'h0) begin errors++; $display("[TB] FAIL seed_result: got found=%b off=%0d expected found=1 off=0", o.found, o.offset); end
    if (o.id !== 3'd0) begin errors++; $display("[TB] FAIL seed_id: got %0d expected 0", o.id); end
    if (o.validAfter !== 1'b0) begin errors++; $display("[TB] FAIL seed_pulse: got res_valid=%b a cycle later expected 0", o.validAfter); end
  endtask

  task automatic test_offset_1000();
    obs_t o;
    logic ef;
    logic [16:0] eo;
    logic [16:0] tgt;
    tgt = stateAt(1000, POLY0);
    refSearch(tgt, POLY0, MAX_A, ef, eo);
    runSearch(0, 2, tgt, 1'b0, o);
    checks += 6;
    if (o.grant !== 4'b0100) begin errors++; $display("[TB] FAIL k1000_grant: got %b expected 0100", o.grant); end
    if (o.found !== ef || o.offset !== eo) begin errors++; $display("[TB] FAIL k1000_result: got found=%b off=%0d expected found=%b off=%0d", o.found, o.offset, ef, eo); end
    if (o.resultCyc - o.acceptCyc != 3 + int'(eo)) begin errors++; $display("[TB] FAIL k1000_latency: got %0d expected %0d", o.resultCyc - o.acceptCyc, 3 + int'(eo)); end
    if (o.polyBad != 0) begin errors++; $display("[TB] FAIL k1000_poly: got %0d bad cycles expected 0", o.polyBad); end
    if (o.enHigh != 3 + int'(eo)) begin errors++; $display("[TB] FAIL k1000_enable: got %0d high cycles expected %0d", o.enHigh, 3 + int'(eo)); end
    if (o.id !== 3'd2) begin errors++; $display("[TB] FAIL k1000_id: got %0d expected 2", o.id); end
  endtask

  task automatic test_random();
    obs_t o;
    logic ef, sel;
    logic [16:0] eo, tgt, poly;
    int id;
    for (int t = 0; t < 6; t++) begin
      id   = $urandom_range(0, 3);
      sel  = 1'($urandom_range(0, 1));
      poly = sel ? POLY1 : POLY0;
      tgt  = stateAt($urandom_range(0, 300), poly);
      refSearch(tgt, poly, MAX_A, ef, eo);
      runSearch(0, id, tgt, sel, o);
      checks += 4;
      if (o.grant !== 4'(1 << id)) begin errors++; $display("[TB] FAIL rand_grant: got %b expected id %0d", o.grant, id); end
      if (o.found !== ef || o.offset !== eo) begin errors++; $display("[TB] FAIL rand_result: got found=%b off=%0d expected found=%b off=%0d", o.found, o.offset, ef, eo); end
      if (o.resultCyc - o.acceptCyc != 3 + int'(eo)) begin errors++; $display("[TB] FAIL rand_latency: got %0d expected %0d", o.resultCyc - o.acceptCyc, 3 + int'(eo)); end
      if (o.id !== 3'(id) || o.polyBad != 0) begin errors++; $display("[TB] FAIL rand_id_poly: got id=%0d badpoly=%0d expected id=%0d badpoly=0", o.id, o.polyBad, id); end
    end
  endtask

  task automatic test_zero_target();
    obs_t o;
    int id;
    id = $urandom_range(0, 3);
    runSearch(0, id, 17'h0, 1'($urandom_range(0, 1)), o);
    checks += 4;
    if (o.resultCyc - o.acceptCyc != 1) begin errors++; $display("[TB] FAIL zero_latency: got %0d expected 1", o.resultCyc - o.acceptCyc); end
    if (o.found !== 1'b0 || o.offset !== 17'h0) begin errors++; $display("[TB] FAIL zero_result: got found=%b off=%0d expected found=0 off=0", o.found, o.offset); end
    if (o.enHigh != 0) begin errors++; $display("[TB] FAIL zero_enable: got %0d high cycles expected 0", o.enHigh); end
    if (o.id !== 3'(id)) begin errors++; $display("[TB] FAIL zero_id: got %0d expected %0d", o.id, id); end
  endtask

  task automatic test_round_robin();
    logic [16:0] tgt[4];
    logic        sel[4];
    logic [3:0]  pending;
    logic        ef;
    logic [16:0] eo;
    int          ptr, expIdx, budget, obsIdx;
    int          order[4];
    int          wantOrder[4];
    bit          reasserted;
    pulseReset();
    ptr = 0;
    reasserted = 1'b0;
    pending = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      sel[i] = 1'($urandom_range(0, 1));
      tgt[i] = stateAt($urandom_range(0, 30), sel[i] ? POLY1 : POLY0);
      reqData[0][17*i +: 17] = tgt[i];
      reqPolySel[0][i] = sel[i];
    end
    reqValid[0] = pending;
    for (int g = 0; g < 4; g++) begin
      expIdx = 0;
      for (int d = 3; d >= 0; d--) if (pending[(ptr + d) % 4]) expIdx = (ptr + d) % 4;
      budget = 0;
      @(negedge clk);
      while (reqReady[0] == 4'h0 && budget < 100) begin budget++; @(negedge clk); end
      obsIdx = -1;
      for (int i = 0; i < 4; i++) if (reqReady[0][i]) obsIdx = i;
      order[g] = obsIdx;
      checks++;
      if (reqReady[0] !== 4'(1 << expIdx)) begin errors++; $display("[TB] FAIL rr_grant: got %b expected id %0d", reqReady[0], expIdx); end
      reqValid[0] = reqValid[0] & ~reqReady[0];
      pending[expIdx] = 1'b0;
      ptr = (expIdx + 1) % 4;
      if (expIdx == 0 && !reasserted) begin
        @(negedge clk);
        reqValid[0][0] = 1'b1;
        pending[0] = 1'b1;
        reasserted = 1'b1;
      end
      budget = 0;
      while (resValid[0] == 1'b0 && budget < 500) begin budget++; @(negedge clk); end
      refSearch(tgt[expIdx], sel[expIdx] ? POLY1 : POLY0, MAX_A, ef, eo);
      checks += 2;
      if (resValid[0] !== 1'b1 || resId[0] !== 3'(expIdx)) begin errors++; $display("[TB] FAIL rr_id: got valid=%b id=%0d expected valid=1 id=%0d", resValid[0], resId[0], expIdx); end
      if (resFound[0] !== ef || resOffset[0] !== eo) begin errors++; $display("[TB] FAIL rr_result: got found=%b off=%0d expected found=%b off=%0d", resFound[0], resOffset[0], ef, eo); end
      @(negedge clk);
    end
    reqValid[0] = 4'h0;
    wantOrder = '{0, 1, 3, 0};
    checks++;
    if (order != wantOrder) begin errors++; $display("[TB] FAIL rr_order: got %0d,%0d,%0d,%0d expected 0,1,3,0", order[0], order[1], order[2], order[3]); end
  endtask

  task automatic test_timeout();
    obs_t o;
    logic ef, sel;
    logic [16:0] eo, tgt, poly;
    sel  = 1'($urandom_range(0, 1));
    poly = sel ? POLY1 : POLY0;
    tgt  = stateAt($urandom_range(100, 400), poly);
    refSearch(tgt, poly, MAX_B, ef, eo);
    runSearch(1, 1, tgt, sel, o);
    checks += 3;
    if (o.found !== ef || o.offset !== eo) begin errors++; $display("[TB] FAIL tmo_result: got found=%b off=%0d expected found=%b off=%0d", o.found, o.offset, ef, eo); end
    if (o.resultCyc - o.acceptCyc != 3 + int'(eo)) begin errors++; $display("[TB] FAIL tmo_latency: got %0d expected %0d", o.resultCyc - o.acceptCyc, 3 + int'(eo)); end
    if (o.timedOut) begin errors++; $display("[TB] FAIL tmo_wait: got no response expected result"); end
    tgt = stateAt($urandom_range(0, 40), POLY0);
    refSearch(tgt, POLY0, MAX_B, ef, eo);
    runSearch(1, 3, tgt, 1'b0, o);
    checks += 2;
    if (o.lowStreak < 2) begin errors++; $display("[TB] FAIL tmo_guard: got %0d enable-low cycles before grant expected >=2", o.lowStreak); end
    if (o.found !== ef || o.offset !== eo) begin errors++; $display("[TB] FAIL tmo_next: got found=%b off=%0d expected found=%b off=%0d", o.found, o.offset, ef, eo); end
  endtask

  task automatic test_reset_mid_search();
    obs_t o;
    logic ef;
    logic [16:0] eo, tgt;
    int budget, seen;
    tgt = stateAt(2000, POLY1);
    reqData[0][17*1 +: 17] = tgt;
    reqPolySel[0][1] = 1'b1;
    reqValid[0][1] = 1'b1;
    budget = 0;
    @(negedge clk);
    while (reqReady[0] == 4'h0 && budget < 100) begin budget++; @(negedge clk); end
    reqValid[0][1] = 1'b0;
    budget = 0;
    while (!(lfsrEnable[0] && lfsrSt[0] == 2 && lfsrIter[0] == 17'd300) && budget < 1000) begin budget++; @(negedge clk); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks += 3;
    if (lfsrEnable[0] !== 1'b0 || resValid[0] !== 1'b0) begin errors++; $display("[TB] FAIL midrst_outputs: got en=%b valid=%b expected 0,0", lfsrEnable[0], resValid[0]); end
    if (lfsrPoly[0] !== POLY0) begin errors++; $display("[TB] FAIL midrst_poly: got %h expected %h", lfsrPoly[0], POLY0); end
    if (resFound[0] !== 1'b0 || resOffset[0] !== 17'h0) begin errors++; $display("[TB] FAIL midrst_res: got found=%b off=%0d expected 0,0", resFound[0], resOffset[0]); end
    seen = 0;
    repeat (2100) begin
      @(negedge clk);
      if (resValid[0]) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("[TB] FAIL midrst_spurious: got %0d results expected 0", seen); end
    tgt = stateAt($urandom_range(200, 400), POLY1);
    refSearch(tgt, POLY1, MAX_A, ef, eo);
    runSearch(0, 1, tgt, 1'b1, o);
    checks += 2;
    if (o.found !== ef || o.offset !== eo) begin errors++; $display("[TB] FAIL midrst_after: got found=%b off=%0d expected found=%b off=%0d", o.found, o.offset, ef, eo); end
    if (o.resultCyc - o.acceptCyc != 3 + int'(eo)) begin errors++; $display("[TB] FAIL midrst_latency: got %0d expected %0d", o.resultCyc - o.acceptCyc, 3 + int'(eo)); end
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      reqValid[k]   = 4'h0;
      reqPolySel[k] = 4'h0;
      reqData[k]    = '0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    test_seed_match();
    test_offset_1000();
    test_random();
    test_zero_target();
    test_round_robin();
    test_timeout();
    test_reset_mid_search();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
